// File: rtl/alu_result_queue.sv
// ALU result queue: DEPTH-entry FIFO of result/flags/tag with valid/ready on both
// sides, plus a sticky overflow flag and a saturating accepted-op counter.
module alu_result_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        result,
  input  logic                     zero,
  input  logic                     cout,
  input  logic                     overflow,
  input  logic [3:0]               ALU_control,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_result,
  output logic [2:0]               out_flags,
  output logic [3:0]               out_ctrl,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_sticky,
  input  logic                     clr_sticky,
  output logic [CNT_W-1:0]         op_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] res_mem_q [DEPTH];
  logic [2:0]        flg_mem_q [DEPTH];
  logic [3:0]        ctl_mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] opc_q, opc_d;

  logic full, empty, push, pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // No pass-through when full: a same-cycle pop does not open in_ready.
  assign in_ready  = !rst && !full;
  assign out_valid = !rst && !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (1'b1)
      (push && !pop): begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        count_d  = count_q + CW'(1);
      end
      (!push && pop): begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        count_d  = count_q - CW'(1);
      end
      (push && pop): begin
        wr_ptr_d = wr_ptr_q + PW'(1);
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    ovf_d = (ovf_q & ~clr_sticky) | (push & overflow);
    opc_d = opc_q;
    if (push && (opc_q != '1)) begin
      opc_d = opc_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      opc_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      opc_q    <= opc_d;
    end
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem_q[wr_ptr_q] <= result;
      flg_mem_q[wr_ptr_q] <= {overflow, cout, zero};
      ctl_mem_q[wr_ptr_q] <= ALU_control;
    end
  end

  assign out_result = out_valid ? res_mem_q[rd_ptr_q] : '0;
  assign out_flags  = out_valid ? flg_mem_q[rd_ptr_q] : '0;
  assign out_ctrl   = out_valid ? ctl_mem_q[rd_ptr_q] : '0;
  assign count      = count_q;
  assign ovf_sticky = ovf_q;
  assign op_count   = opc_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// Bench for alu_result_queue: directed + random stimulus, queue-based reference
// model feeding a scoreboard that a negedge monitor checks against the DUT.
module tb_alu_result_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int OPMAX = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   result = '0;
  logic            zero = 1'b0;
  logic            cout = 1'b0;
  logic            overflow = 1'b0;
  logic [3:0]      ALU_control = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_result;
  logic [2:0]      out_flags;
  logic [3:0]      out_ctrl;
  logic [2:0]      count;
  logic            ovf_sticky;
  logic            clr_sticky = 1'b0;
  logic [CNT_W-1:0] op_count;

  alu_result_queue #(
    .DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .zero(zero), .cout(cout),
    .overflow(overflow), .ALU_control(ALU_control),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags),
    .out_ctrl(out_ctrl), .count(count),
    .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  fl;
    logic [3:0]  ctl;
  } ent_t;

  ent_t exp_q[$];
  bit   m_rdy = 1'b0;
  bit   m_ovf = 1'b0;
  int   m_opc = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: accepted pushes enqueue the expected entry.
  always @(posedge clk) begin
    bit p;
    if (rst) begin
      exp_q.delete();
      m_ovf = 1'b0;
      m_opc = 0;
    end else begin
      p = in_valid && m_rdy;
      if (p) exp_q.push_back('{result, {overflow, cout, zero}, ALU_control});
      m_ovf = (m_ovf && !clr_sticky) || (p && overflow);
      if (p && m_opc < OPMAX) m_opc++;
    end
  end

  // Monitor: mid-cycle compare, then retire head if consumer takes it.
  always @(negedge clk) begin
    bit ev;
    ev    = !rst && exp_q.size() != 0;
    m_rdy = !rst && exp_q.size() != DEPTH;
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("count", 32'(count), 32'(exp_q.size()));
    chk("ovf_sticky", 32'(ovf_sticky), 32'(m_ovf));
    chk("op_count", 32'(op_count), 32'(m_opc));
    if (ev) begin
      chk("out_result", out_result, exp_q[0].res);
      chk("out_flags", 32'(out_flags), 32'(exp_q[0].fl));
      chk("out_ctrl", 32'(out_ctrl), 32'(exp_q[0].ctl));
      if (out_ready) void'(exp_q.pop_front());
    end else begin
      chk("out_result_idle", out_result, 32'd0);
      chk("out_flags_idle", 32'(out_flags), 32'd0);
      chk("out_ctrl_idle", 32'(out_ctrl), 32'd0);
    end
  end

  task automatic drv(input logic r, input logic iv, input logic [31:0] res,
                     input logic [2:0] fl, input logic [3:0] ctl,
                     input logic ordy, input logic clr);
    rst         = r;
    in_valid    = iv;
    result      = res;
    {overflow, cout, zero} = fl;
    ALU_control = ctl;
    out_ready   = ordy;
    clr_sticky  = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset two cycles
    drv(1, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0, 0);
    // single push, hold
    drv(0, 1, 32'h5, 3'b000, 4'b0010, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 0);
    // fill, overfill, drain
    for (int i = 1; i <= 5; i++) drv(0, 1, 32'(i), 3'(i), 4'(i), 0, 0);
    for (int i = 0; i < 6; i++) drv(0, 0, 0, 0, 0, 1, 0);
    // two entries then push+pop across wrap
    drv(0, 1, 32'hA, 3'b001, 4'h1, 0, 0);
    drv(0, 1, 32'hB, 3'b010, 4'h2, 0, 0);
    for (int i = 0; i < 6; i++) drv(0, 1, 32'h70 + 32'(i), 3'b011, 4'h7, 1, 0);
    for (int i = 0; i < 3; i++) drv(0, 0, 0, 0, 0, 1, 0);
    // sticky: set wins over clear, then clear alone
    drv(0, 1, 32'h8000_0000, 3'b100, 4'h3, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 1, 0);
    // reset with three entries and coincident push/pop
    for (int i = 0; i < 3; i++) drv(0, 1, 32'h30 + 32'(i), 3'b000, 4'h4, 0, 0);
    drv(1, 1, 32'hDEAD, 3'b111, 4'hF, 1, 0);
    // op_count saturation
    for (int i = 0; i < 17; i++) drv(0, 1, 32'(i), 3'b000, 4'h5, 1, 0);
    @(negedge clk);
    chk("op_count_sat", 32'(op_count), 32'(OPMAX));
    @(posedge clk);
    #1;
    // random
    for (int i = 0; i < 400; i++) begin
      drv(($urandom_range(0, 60) == 0), 1'($urandom), $urandom,
          3'($urandom), 4'($urandom), 1'($urandom),
          ($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 8; i++) drv(0, 0, 0, 0, 0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
